// File: rtl/em_stage_defs.sv
// em_stage_defs: shared definitions for the E->M pipeline register slice.
//   - Default datapath / register-address widths.
//   - Stall-controller state encoding (RUN, LOAD_STALL).
//   - Bubble constants loaded into the M control flags on a squash or stall.
package em_stage_defs;

    localparam int unsigned DWIDTH_DEF = 32;
    localparam int unsigned AWIDTH_DEF = 5;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } emState_t;

    localparam logic BUBBLE_REG_WRITE = 1'b0;
    localparam logic BUBBLE_MEM_TO_REG = 1'b0;
    localparam logic BUBBLE_MEM_WRITE = 1'b0;

endpackage

// File: rtl/em_hazard_detect.sv
// em_hazard_detect: combinational load-use hazard and hold-forward select logic.
// Ports:
//   state                 stall-controller state
//   regWriteM, memToRegM  flags of the instruction in M
//   waM                   destination of the instruction in M
//   holdWa                destination captured with the held load data
//   rsE, rtE              E source registers
//   usesRsE, usesRtE      E reads rs / rt
//   hazard                E depends on a load still in M (RUN only)
//   fwdAfromHoldE/BE      E operand A/B takes holdData (LOAD_STALL only)
module em_hazard_detect
    import em_stage_defs::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF
) (
    input  emState_t          state,
    input  logic              regWriteM,
    input  logic              memToRegM,
    input  logic [AWIDTH-1:0] waM,
    input  logic [AWIDTH-1:0] holdWa,
    input  logic [AWIDTH-1:0] rsE,
    input  logic [AWIDTH-1:0] rtE,
    input  logic              usesRsE,
    input  logic              usesRtE,
    output logic              hazard,
    output logic              fwdAfromHoldE,
    output logic              fwdBfromHoldE
);

    always_comb begin
        hazard        = 1'b0;
        fwdAfromHoldE = 1'b0;
        fwdBfromHoldE = 1'b0;
        if (state == RUN) begin
            // Register 0 is hardwired, so a load targeting it never stalls.
            hazard = regWriteM && memToRegM && (waM != '0) &&
                     ((usesRsE && (rsE == waM)) || (usesRtE && (rtE == waM)));
        end else begin
            fwdAfromHoldE = usesRsE && (rsE == holdWa) && (holdWa != '0);
            fwdBfromHoldE = usesRtE && (rtE == holdWa) && (holdWa != '0);
        end
    end

endmodule

// File: rtl/em_stage_reg.sv
// em_stage_reg: E->M pipeline register with load-use stall controller.
// A load in M feeding the instruction in E stalls F/E for one cycle, puts a
// bubble into M and captures the load data into holdData; the following
// cycle E takes the operand from holdData. dmemStall freezes everything;
// flushE squashes E into a bubble unless a load-use stall is being taken.
// Configuration macro: EM_STALL_COUNTER_EN enables the saturating
// stallCount counter; otherwise stallCount is tied to zero.
// Ports:
//   clk, rst (async, active-high)
//   E inputs : aluOutE, writeDataE, waE, regWriteE, memToRegE, memWriteE,
//              rsE, rtE, usesRsE, usesRtE, flushE
//   memory   : dmemStall, dmemRdata
//   M outputs: aluOutM, writeDataM, waM, regWriteM, memToRegM, memWriteM
//   control  : stallF, stallE, fwdAfromHoldE, fwdBfromHoldE, holdData,
//              stallCount
module em_stage_reg
    import em_stage_defs::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] aluOutE,
    input  logic [DWIDTH-1:0] writeDataE,
    input  logic [AWIDTH-1:0] waE,
    input  logic              regWriteE,
    input  logic              memToRegE,
    input  logic              memWriteE,
    input  logic [AWIDTH-1:0] rsE,
    input  logic [AWIDTH-1:0] rtE,
    input  logic              usesRsE,
    input  logic              usesRtE,
    input  logic              flushE,
    input  logic              dmemStall,
    input  logic [DWIDTH-1:0] dmemRdata,
    output logic [DWIDTH-1:0] aluOutM,
    output logic [DWIDTH-1:0] writeDataM,
    output logic [AWIDTH-1:0] waM,
    output logic              regWriteM,
    output logic              memToRegM,
    output logic              memWriteM,
    output logic              stallF,
    output logic              stallE,
    output logic              fwdAfromHoldE,
    output logic              fwdBfromHoldE,
    output logic [DWIDTH-1:0] holdData,
    output logic [31:0]       stallCount
);

    emState_t          state, stateNext;
    logic [AWIDTH-1:0] holdWa;
    logic              hazard;

    em_hazard_detect #(
        .AWIDTH(AWIDTH)
    ) uHazard (
        .state        (state),
        .regWriteM    (regWriteM),
        .memToRegM    (memToRegM),
        .waM          (waM),
        .holdWa       (holdWa),
        .rsE          (rsE),
        .rtE          (rtE),
        .usesRsE      (usesRsE),
        .usesRtE      (usesRtE),
        .hazard       (hazard),
        .fwdAfromHoldE(fwdAfromHoldE),
        .fwdBfromHoldE(fwdBfromHoldE)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        stallF    = 1'b0;
        stallE    = 1'b0;
        if (dmemStall) begin
            stallF = 1'b1;
            stallE = 1'b1;
        end else if (hazard) begin
            stallF    = 1'b1;
            stallE    = 1'b1;
            stateNext = LOAD_STALL;
        end else begin
            stateNext = RUN;
        end
    end

    // hazard is only ever raised in RUN, so the LOAD_STALL cycle falls
    // through to the normal capture/flush path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluOutM    <= '0;
            writeDataM <= '0;
            waM        <= '0;
            regWriteM  <= 1'b0;
            memToRegM  <= 1'b0;
            memWriteM  <= 1'b0;
            holdData   <= '0;
            holdWa     <= '0;
        end else if (!dmemStall) begin
            if (hazard || flushE) begin
                aluOutM    <= '0;
                writeDataM <= '0;
                waM        <= '0;
                regWriteM  <= BUBBLE_REG_WRITE;
                memToRegM  <= BUBBLE_MEM_TO_REG;
                memWriteM  <= BUBBLE_MEM_WRITE;
            end else begin
                aluOutM    <= aluOutE;
                writeDataM <= writeDataE;
                waM        <= waE;
                regWriteM  <= regWriteE;
                memToRegM  <= memToRegE;
                memWriteM  <= memWriteE;
            end
            if (hazard) begin
                holdData <= dmemRdata;
                holdWa   <= waM;
            end
        end
    end

`ifdef EM_STALL_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= '0;
        end else if (hazard && !dmemStall && (stallCount != '1)) begin
            stallCount <= stallCount + 32'd1;
        end
    end
`else
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_em_stage_reg.sv
// Directed-vector bench for em_stage_reg.
module tb_em_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluOutE, writeDataE, dmemRdata;
    logic [4:0]  waE, rsE, rtE;
    logic        regWriteE, memToRegE, memWriteE, usesRsE, usesRtE, flushE, dmemStall;
    logic [31:0] aluOutM, writeDataM, holdData, stallCount;
    logic [4:0]  waM;
    logic        regWriteM, memToRegM, memWriteM, stallF, stallE, fwdAfromHoldE, fwdBfromHoldE;

    int vectors = 0;
    int miscompares = 0;

    em_stage_reg #(.DWIDTH(32), .AWIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .aluOutE(aluOutE), .writeDataE(writeDataE), .waE(waE),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .rsE(rsE), .rtE(rtE), .usesRsE(usesRsE), .usesRtE(usesRtE),
        .flushE(flushE), .dmemStall(dmemStall), .dmemRdata(dmemRdata),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .waM(waM),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .stallF(stallF), .stallE(stallE),
        .fwdAfromHoldE(fwdAfromHoldE), .fwdBfromHoldE(fwdBfromHoldE),
        .holdData(holdData), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setE(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wa,
                        input logic rw, input logic m2r, input logic mw,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt);
        aluOutE = alu; writeDataE = wd; waE = wa;
        regWriteE = rw; memToRegE = m2r; memWriteE = mw;
        rsE = rs; rtE = rt; usesRsE = urs; usesRtE = urt;
    endtask

    task automatic test_reset();
        rst = 1'b1; flushE = 1'b0; dmemStall = 1'b0; dmemRdata = '0;
        setE(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        vectors++; if (regWriteM !== 1'b0 || waM !== 5'd0 || aluOutM !== 32'h0) begin $display("FAIL reset_m: rw=%b wa=%0d alu=%h want 0", regWriteM, waM, aluOutM); miscompares++; end
        vectors++; if (stallF !== 1'b0 || stallE !== 1'b0 || fwdAfromHoldE !== 1'b0 || fwdBfromHoldE !== 1'b0) begin $display("FAIL reset_ctl: sF=%b sE=%b fA=%b fB=%b want 0", stallF, stallE, fwdAfromHoldE, fwdBfromHoldE); miscompares++; end
        vectors++; if (holdData !== 32'h0 || stallCount !== 32'h0) begin $display("FAIL reset_hold: hd=%h cnt=%0d want 0", holdData, stallCount); miscompares++; end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_midrun();
        setE(32'h1234, 32'h99, 5'd7, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++; if (regWriteM !== 1'b1 || waM !== 5'd7) begin $display("FAIL midrun_pre: rw=%b wa=%0d want 1/7", regWriteM, waM); miscompares++; end
        rst = 1'b1;
        #1;
        vectors++; if (regWriteM !== 1'b0 || waM !== 5'd0 || aluOutM !== 32'h0 || memWriteM !== 1'b0) begin $display("FAIL midrun_async: rw=%b wa=%0d alu=%h mw=%b want 0", regWriteM, waM, aluOutM, memWriteM); miscompares++; end
        tick();
        rst = 1'b0;
        // reset taken while in LOAD_STALL clears the forward selects too
        dmemRdata = 32'hCAFE0001;
        setE(32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        setE(32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd10, 5'd0, 1'b1, 1'b0);
        tick();
        vectors++; if (fwdAfromHoldE !== 1'b1 || holdData !== 32'hCAFE0001) begin $display("FAIL midrun_ls_pre: fA=%b hd=%h want 1/cafe0001", fwdAfromHoldE, holdData); miscompares++; end
        rst = 1'b1;
        #1;
        vectors++; if (fwdAfromHoldE !== 1'b0 || holdData !== 32'h0 || stallF !== 1'b0) begin $display("FAIL midrun_ls_async: fA=%b hd=%h sF=%b want 0", fwdAfromHoldE, holdData, stallF); miscompares++; end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        dmemRdata = 32'hDEADBEEF;
        setE(32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        setE(32'h55, 32'h66, 5'd3, 1'b1, 1'b0, 1'b0, 5'd10, 5'd2, 1'b1, 1'b0);
        #1;
        vectors++; if (stallF !== 1'b1 || stallE !== 1'b1 || fwdAfromHoldE !== 1'b0) begin $display("FAIL lu_hazard: sF=%b sE=%b fA=%b want 1/1/0", stallF, stallE, fwdAfromHoldE); miscompares++; end
        tick();
        vectors++; if (regWriteM !== 1'b0 || memToRegM !== 1'b0 || fwdAfromHoldE !== 1'b1 || fwdBfromHoldE !== 1'b0) begin $display("FAIL lu_bubble: rw=%b m2r=%b fA=%b fB=%b want 0/0/1/0", regWriteM, memToRegM, fwdAfromHoldE, fwdBfromHoldE); miscompares++; end
        vectors++; if (holdData !== 32'hDEADBEEF || stallF !== 1'b0) begin $display("FAIL lu_hold: hd=%h sF=%b want deadbeef/0", holdData, stallF); miscompares++; end
        tick();
        vectors++; if (waM !== 5'd3 || aluOutM !== 32'h55 || writeDataM !== 32'h66 || regWriteM !== 1'b1) begin $display("FAIL lu_capture: wa=%0d alu=%h wd=%h rw=%b want 3/55/66/1", waM, aluOutM, writeDataM, regWriteM); miscompares++; end
        vectors++; if (stallF !== 1'b0 || fwdAfromHoldE !== 1'b0) begin $display("FAIL lu_after: sF=%b fA=%b want 0/0", stallF, fwdAfromHoldE); miscompares++; end
    endtask

    task automatic test_reg0();
        setE(32'h200, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        setE(32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        vectors++; if (stallF !== 1'b0 || stallE !== 1'b0) begin $display("FAIL r0_nostall: sF=%b sE=%b want 0", stallF, stallE); miscompares++; end
        tick();
        vectors++; if (waM !== 5'd4 || aluOutM !== 32'h77 || regWriteM !== 1'b1) begin $display("FAIL r0_capture: wa=%0d alu=%h rw=%b want 4/77/1", waM, aluOutM, regWriteM); miscompares++; end
    endtask

    task automatic test_dmem_stall();
        dmemRdata = 32'h12345678;
        setE(32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        setE(32'h88, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd1, 5'd10, 1'b0, 1'b1);
        dmemStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (stallF !== 1'b1 || stallE !== 1'b1 || waM !== 5'd10 || memToRegM !== 1'b1 || aluOutM !== 32'h300 || fwdBfromHoldE !== 1'b0) begin $display("FAIL dm_freeze%0d: sF=%b sE=%b wa=%0d m2r=%b alu=%h fB=%b want 1/1/10/1/300/0", i, stallF, stallE, waM, memToRegM, aluOutM, fwdBfromHoldE); miscompares++; end
        end
        dmemStall = 1'b0;
        #1;
        vectors++; if (stallF !== 1'b1) begin $display("FAIL dm_hazard: sF=%b want 1", stallF); miscompares++; end
        tick();
        vectors++; if (regWriteM !== 1'b0 || fwdBfromHoldE !== 1'b1 || fwdAfromHoldE !== 1'b0 || holdData !== 32'h12345678) begin $display("FAIL dm_bubble: rw=%b fB=%b fA=%b hd=%h want 0/1/0/12345678", regWriteM, fwdBfromHoldE, fwdAfromHoldE, holdData); miscompares++; end
        tick();
        vectors++; if (waM !== 5'd6 || aluOutM !== 32'h88 || stallF !== 1'b0) begin $display("FAIL dm_capture: wa=%0d alu=%h sF=%b want 6/88/0", waM, aluOutM, stallF); miscompares++; end
    endtask

    task automatic test_flush();
        setE(32'h400, 32'h44, 5'd5, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        flushE = 1'b1;
        tick();
        vectors++; if (regWriteM !== 1'b0 || memWriteM !== 1'b0 || waM !== 5'd0) begin $display("FAIL fl_bubble: rw=%b mw=%b wa=%0d want 0/0/0", regWriteM, memWriteM, waM); miscompares++; end
        flushE = 1'b0;
        dmemRdata = 32'h0BADF00D;
        setE(32'h500, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        setE(32'h99, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 5'd10, 5'd0, 1'b1, 1'b0);
        flushE = 1'b1;
        #1;
        vectors++; if (stallF !== 1'b1) begin $display("FAIL fl_hazard: sF=%b want 1", stallF); miscompares++; end
        tick();
        vectors++; if (fwdAfromHoldE !== 1'b1 || holdData !== 32'h0BADF00D || regWriteM !== 1'b0) begin $display("FAIL fl_ignored: fA=%b hd=%h rw=%b want 1/0badf00d/0", fwdAfromHoldE, holdData, regWriteM); miscompares++; end
        tick();
        vectors++; if (regWriteM !== 1'b0 || waM !== 5'd0 || fwdAfromHoldE !== 1'b0) begin $display("FAIL fl_ls_squash: rw=%b wa=%0d fA=%b want 0/0/0", regWriteM, waM, fwdAfromHoldE); miscompares++; end
        flushE = 1'b0;
    endtask

    task automatic test_back_to_back();
        dmemRdata = 32'hAAAA0001;
        setE(32'h600, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        setE(32'h604, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 1'b1, 1'b0);
        #1;
        vectors++; if (stallF !== 1'b1) begin $display("FAIL b2b_h1: sF=%b want 1", stallF); miscompares++; end
        tick();
        vectors++; if (holdData !== 32'hAAAA0001 || fwdAfromHoldE !== 1'b1) begin $display("FAIL b2b_ls1: hd=%h fA=%b want aaaa0001/1", holdData, fwdAfromHoldE); miscompares++; end
        dmemRdata = 32'hBBBB0002;
        tick();
        vectors++; if (waM !== 5'd11 || memToRegM !== 1'b1 || regWriteM !== 1'b1) begin $display("FAIL b2b_load2: wa=%0d m2r=%b rw=%b want 11/1/1", waM, memToRegM, regWriteM); miscompares++; end
        setE(32'hAB, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 1'b0, 1'b1);
        #1;
        vectors++; if (stallF !== 1'b1 || stallE !== 1'b1) begin $display("FAIL b2b_h2: sF=%b sE=%b want 1/1", stallF, stallE); miscompares++; end
        tick();
        vectors++; if (holdData !== 32'hBBBB0002 || fwdBfromHoldE !== 1'b1 || regWriteM !== 1'b0) begin $display("FAIL b2b_ls2: hd=%h fB=%b rw=%b want bbbb0002/1/0", holdData, fwdBfromHoldE, regWriteM); miscompares++; end
        tick();
        vectors++; if (waM !== 5'd12 || aluOutM !== 32'hAB) begin $display("FAIL b2b_capture: wa=%0d alu=%h want 12/ab", waM, aluOutM); miscompares++; end
    endtask

    task automatic test_stall_counter();
        logic [31:0] expCount;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setE(32'h700, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
            setE(32'h1, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0);
            tick();
            tick();
        end
`ifdef EM_STALL_COUNTER_EN
        expCount = 32'd3;
`else
        expCount = 32'd0;
`endif
        vectors++; if (stallCount !== expCount) begin $display("FAIL stall_count: got %0d want %0d", stallCount, expCount); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_load_use();
        test_reg0();
        test_dmem_stall();
        test_flush();
        test_back_to_back();
        test_stall_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/em_stage_reg.md
Name: em_stage_reg

Overview:
- Execute-to-memory pipeline register plus load-use stall controller for the 3-stage (F/E/M) MIPS core.
- Produces the M-stage signals that the forwarding unit consumes: waM, regWriteM and aluOutM.
- Detects when an instruction in E uses the result of a load still in M. Stalls F/E for one cycle, inserts a bubble, and forwards the held load data afterwards.
- Also freezes the pipe on data-memory stall and squashes E on branch flush.

Parameters:
- DWIDTH, 32, datapath width
- AWIDTH, 5, register address width

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- aluOutE  in  DWIDTH  ALU result in E
- writeDataE  in  DWIDTH  store data in E
- waE  in  AWIDTH  destination register in E
- regWriteE  in  1  E writes the register file
- memToRegE  in  1  E is a load
- memWriteE  in  1  E is a store
- rsE  in  AWIDTH  E source A
- rtE  in  AWIDTH  E source B
- usesRsE  in  1  E reads rs
- usesRtE  in  1  E reads rt
- flushE  in  1  squash the E instruction (branch redirect)
- dmemStall  in  1  data memory not ready
- dmemRdata  in  DWIDTH  load data returned for the M instruction
- aluOutM  out  DWIDTH  registered ALU result
- writeDataM  out  DWIDTH  registered store data
- waM  out  AWIDTH  registered destination
- regWriteM  out  1  registered write enable
- memToRegM  out  1  registered load flag
- memWriteM  out  1  registered store flag
- stallF  out  1  hold F
- stallE  out  1  hold E
- fwdAfromHoldE  out  1  select holdData for E operand A
- fwdBfromHoldE  out  1  select holdData for E operand B
- holdData  out  DWIDTH  captured load data
- stallCount  out  32  load-use stall cycles (see Optional Feature)

Behaviour:
- Reset (async):
  - All M registers = 0; regWriteM = memToRegM = memWriteM = 0.
  - holdData = 0, holdWa = 0; state = RUN; stallCount = 0.
  - Combinational outputs evaluate to 0 from the reset register values.
- hazard (combinational):
  - Condition: state==RUN AND regWriteM AND memToRegM AND waM!=0 AND ((usesRsE AND rsE==waM) OR (usesRtE AND rtE==waM)).
  - Register 0 never causes a hazard.
- Priority: dmemStall > hazard > flushE > normal.
- dmemStall=1:
  - stallF = stallE = 1.
  - All registers and state hold.
  - Hold-forward outputs are still driven from the current state.
- hazard=1 (dmemStall=0):
  - stallF = stallE = 1.
  - At the clock edge: M is loaded with a bubble (regWriteM = memToRegM = memWriteM = 0; data and addresses are don't-care, driven 0); holdData <= dmemRdata; holdWa <= waM; state <= LOAD_STALL.
  - flushE is ignored this cycle.
- LOAD_STALL (one cycle only):
  - stallF = stallE = 0.
  - fwdAfromHoldE = usesRsE AND rsE==holdWa AND holdWa!=0; fwdBfromHoldE is the same with rt.
  - At the edge: M <= E (or a bubble if flushE); state <= RUN.
  - hazard is not evaluated in LOAD_STALL, because M holds a bubble.
- RUN with no hazard:
  - At the edge: M <= E values, or a bubble if flushE=1.
  - Hold-forward outputs = 0.
- Latency: E to M is 1 cycle; a load-use costs exactly 1 bubble.
- Back-to-back loads: a load immediately following a load with a dependency re-triggers hazard after returning to RUN.

Optional Feature:
- Macro: EM_STALL_COUNTER_EN.
- Defined:
  - stallCount increments by 1 on each edge where hazard=1 and dmemStall=0.
  - Saturates at 0xFFFFFFFF.
  - Reset clears it.
- Undefined: stallCount is tied to 0 and no counter flops exist.

Decomposition:
- Shared package/header (em_stage_defs):
  - State encoding, RUN=1'b0 and LOAD_STALL=1'b1.
  - Bubble constants.
  - DWIDTH/AWIDTH defaults.
- Sub-module em_hazard_detect: purely combinational.
  - Computes hazard and the two hold-forward selects from waM, holdWa, the flags, state and the E operands.

Test Plan:
- Reset asserted mid-run with regWriteM=1, waM=7 -> all outputs 0 immediately, without waiting for a clock edge; state RUN.
- lw in M with waM=10 and memToRegM=1; E has rsE=10, usesRsE=1; dmemRdata=0xDEADBEEF.
  - Hazard cycle: stallF = stallE = 1.
  - Next cycle: regWriteM=0 (bubble), fwdAfromHoldE=1, holdData=0xDEADBEEF.
  - Following cycle: M captures E; stall = 0.
- Same as the load-use case but waM=0 -> no stall; M captures E normally.
- Hazard with dmemStall=1 for 3 cycles -> M and state frozen, stall held high; after dmemStall drops, the 1-cycle load-use sequence proceeds.
- RUN, regWriteE=1, waE=5, flushE=1 -> next cycle regWriteM=0, memWriteM=0; with hazard also present, flushE is ignored.
- EM_STALL_COUNTER_EN defined: three separate load-use events -> stallCount=3; macro undefined -> stallCount stays 0.
